div_share_arbiter: RTL and testbench

// - Shares one pipelined divider (div_wrapper_pipe) between N_REQ PEs of a PEA row/column.
// - Per-cycle round-robin arbitration among division requests; at most one issue per cycle.
// - The granted requester index travels beside the operands in a tag FIFO.
// - Each result is steered back to the requester that issued it, in issue order.
// - Sits between PE FU wrappers (DIV/REM issue side) and a single shared divider instance.

---
 rtl/pea_pkg.sv | 10 +
 rtl/div_share_arbiter_tag_fifo.sv | 52 +++++
 rtl/div_wrapper_pipe.sv | 65 ++++++
 rtl/div_share_arbiter.sv | 105 ++++++++++
 tb/tb_div_share_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pea_pkg.sv
// Shared PEA definitions: datapath width and divider-sharing defaults.
// Imported by the shared-divider arbiter and its helpers.
package pea_pkg;

   localparam int N_BITS = 32;
   localparam int DIV_ARB_N_REQ = 4;

   typedef logic [$clog2(DIV_ARB_N_REQ)-1:0] div_tag_t;

endpackage

// File: rtl/div_share_arbiter_tag_fifo.sv
// Circular tag buffer recording which requester owns each in-flight divide.
// Push and pop together are accepted even when full.
module tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_o == CW'(DEPTH));
   assign empty_o = (count_o == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = mem[rd_ptr];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din_i;
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         if (do_push && !do_pop)
            count_o <= count_o + CW'(1);
         else if (do_pop && !do_push)
            count_o <= count_o - CW'(1);
      end
   end

endmodule

// File: rtl/div_wrapper_pipe.sv
// Signed divider with a fixed LAT-stage pipeline, frozen when pea_ready_i is low.
// Divide-by-zero gives q=-1,r=a; MIN/-1 overflow gives q=MIN,r=0.
module div_wrapper_pipe
   import pea_pkg::*;
#(
   parameter int LAT = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              pea_ready_i,
   input  logic              in_valid_i,
   input  logic [N_BITS-1:0] a_i,
   input  logic [N_BITS-1:0] b_i,
   output logic              valid_o,
   output logic [N_BITS-1:0] q_o,
   output logic [N_BITS-1:0] r_o
);

   localparam logic [N_BITS-1:0] MIN = {1'b1, {(N_BITS-1){1'b0}}};

   logic [N_BITS-1:0] q_c;
   logic [N_BITS-1:0] r_c;
   logic [LAT-1:0]    vld;
   logic [N_BITS-1:0] qp [LAT];
   logic [N_BITS-1:0] rp [LAT];

   always_comb begin
      q_c = '0;
      r_c = '0;
      if (b_i == '0) begin
         q_c = '1;
         r_c = a_i;
      end else if (a_i == MIN && b_i == '1) begin
         q_c = MIN;
         r_c = '0;
      end else begin
         q_c = $signed(a_i) / $signed(b_i);
         r_c = $signed(a_i) % $signed(b_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld <= '0;
         for (int i = 0; i < LAT; i++) begin
            qp[i] <= '0;
            rp[i] <= '0;
         end
      end else if (pea_ready_i) begin
         vld[0] <= in_valid_i;
         qp[0]  <= q_c;
         rp[0]  <= r_c;
         for (int i = 1; i < LAT; i++) begin
            vld[i] <= vld[i-1];
            qp[i]  <= qp[i-1];
            rp[i]  <= rp[i-1];
         end
      end
   end

   assign valid_o = vld[LAT-1];
   assign q_o     = qp[LAT-1];
   assign r_o     = rp[LAT-1];

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one pipelined divider among N_REQ PEs.
// A tag FIFO steers each result back to its issuer in issue order.
module div_share_arbiter
   import pea_pkg::*;
#(
   parameter int N_REQ = DIV_ARB_N_REQ,
   parameter int DIV_LAT = 4,
   localparam int TW = $clog2(N_REQ),
   localparam int OW = $clog2(DIV_LAT + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    pea_ready_i,
   input  logic [N_REQ-1:0]        req_valid_i,
   input  logic [N_REQ*N_BITS-1:0] req_a_i,
   input  logic [N_REQ*N_BITS-1:0] req_b_i,
   output logic [N_REQ-1:0]        req_ready_o,
   output logic [N_REQ-1:0]        rsp_valid_o,
   output logic [N_BITS-1:0]       rsp_q_o,
   output logic [N_BITS-1:0]       rsp_r_o,
   output logic [OW-1:0]           outstanding_o,
   output logic                    err_o
);

   logic [TW-1:0]     rr_ptr;
   logic [TW-1:0]     grant_idx;
   logic [TW-1:0]     head;
   logic              grant_any;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              div_valid;
   logic [N_BITS-1:0] div_a;
   logic [N_BITS-1:0] div_b;
   int                idx;

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      idx = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!grant_any && req_valid_i[idx]) begin
            grant_any = 1'b1;
            grant_idx = TW'(idx);
         end
      end
   end

   // A full FIFO only frees a slot when the head result leaves this cycle.
   assign pop  = div_valid & pea_ready_i & ~fifo_empty;
   assign push = grant_any & pea_ready_i & (~fifo_full | pop);

   assign req_ready_o = push ? (N_REQ'(1) << grant_idx) : '0;
   assign div_a = push ? req_a_i[grant_idx*N_BITS +: N_BITS] : '0;
   assign div_b = push ? req_b_i[grant_idx*N_BITS +: N_BITS] : '0;

   assign rsp_valid_o = (div_valid && !fifo_empty)
                        ? (N_REQ'(1) << head) : '0;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rr_ptr <= '0;
         err_o  <= 1'b0;
      end else begin
         if (push)
            rr_ptr <= (grant_idx == TW'(N_REQ - 1))
                      ? '0 : grant_idx + TW'(1);
         if (div_valid && fifo_empty)
            err_o <= 1'b1;
      end
   end

   tag_fifo #(
      .DEPTH (DIV_LAT),
      .WIDTH (TW)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (grant_idx),
      .dout_o  (head),
      .count_o (outstanding_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   div_wrapper_pipe #(
      .LAT (DIV_LAT)
   ) u_div (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .pea_ready_i (pea_ready_i),
      .in_valid_i  (push),
      .a_i         (div_a),
      .b_i         (div_b),
      .valid_o     (div_valid),
      .q_o         (rsp_q_o),
      .r_o         (rsp_r_o)
   );

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomized bench for div_share_arbiter against a queue-based reference model.
module tb_div_share_arbiter;
   import pea_pkg::*;

   localparam int NR  = 4;
   localparam int LAT = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           pea_ready;
   logic [NR-1:0]  req_valid;
   logic [NR*32-1:0] req_a;
   logic [NR*32-1:0] req_b;
   logic [NR-1:0]  req_ready;
   logic [NR-1:0]  rsp_valid;
   logic [31:0]    rsp_q;
   logic [31:0]    rsp_r;
   logic [2:0]     outstanding;
   logic           err;

   int total = 0;
   int bad = 0;

   logic [31:0] ta [NR];
   logic [31:0] tb_ [NR];

   typedef struct {
      int pe;
      logic [31:0] q;
      logic [31:0] r;
      int due;
   } exp_t;

   exp_t eq[$];
   int m_rr;
   int act;

   always #5 clk = ~clk;

   div_share_arbiter #(.N_REQ(NR), .DIV_LAT(LAT)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .pea_ready_i   (pea_ready),
      .req_valid_i   (req_valid),
      .req_a_i       (req_a),
      .req_b_i       (req_b),
      .req_ready_o   (req_ready),
      .rsp_valid_o   (rsp_valid),
      .rsp_q_o       (rsp_q),
      .rsp_r_o       (rsp_r),
      .outstanding_o (outstanding),
      .err_o         (err)
   );

   function automatic logic [63:0] ref_div(input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa;
      longint sb;
      longint lq;
      longint lr;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sa == -64'sd2147483648 && sb == -64'sd1)
         return {32'h8000_0000, 32'd0};
      lq = sa / sb;
      lr = sa - lq * sb;
      return {lq[31:0], lr[31:0]};
   endfunction

   task automatic apply(input logic [NR-1:0] v, input logic pr);
      req_valid = v;
      pea_ready = pr;
      for (int i = 0; i < NR; i++) begin
         req_a[i*32 +: 32] = ta[i];
         req_b[i*32 +: 32] = tb_[i];
      end
   endtask

   // One clock of stimulus, scored against the model, then advance.
   task automatic drive_cycle(input logic [NR-1:0] v, input logic pr);
      logic [NR-1:0] exp_rdy;
      logic [NR-1:0] exp_rsp;
      logic [63:0] qr;
      logic pop_e;
      int g;
      int id;
      exp_t e;
      apply(v, pr);
      #2;
      exp_rsp = '0;
      pop_e = 1'b0;
      if (eq.size() > 0 && eq[0].due == act) begin
         exp_rsp[eq[0].pe] = 1'b1;
         pop_e = pr;
      end
      g = -1;
      if (pr && (eq.size() < LAT || pop_e)) begin
         for (int k = 0; k < NR; k++) begin
            id = (m_rr + k) % NR;
            if (g < 0 && v[id]) g = id;
         end
      end
      exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
      total++;
      if (req_ready !== exp_rdy) begin
         bad++;
         $display("FAIL grant t=%0t got=%b want=%b", $time, req_ready, exp_rdy);
      end
      total++;
      if (rsp_valid !== exp_rsp) begin
         bad++;
         $display("FAIL rsp_valid t=%0t got=%b want=%b", $time, rsp_valid, exp_rsp);
      end
      if (exp_rsp != '0) begin
         total++;
         if (rsp_q !== eq[0].q || rsp_r !== eq[0].r) begin
            bad++;
            $display("FAIL rsp_data t=%0t got=%h/%h want=%h/%h",
                     $time, rsp_q, rsp_r, eq[0].q, eq[0].r);
         end
      end
      total++;
      if (int'(outstanding) !== eq.size()) begin
         bad++;
         $display("FAIL outstanding t=%0t got=%0d want=%0d",
                  $time, outstanding, eq.size());
      end
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL err t=%0t got=%b want=0", $time, err);
      end
      if (pr) begin
         if (pop_e) void'(eq.pop_front());
         if (g >= 0) begin
            qr = ref_div(ta[g], tb_[g]);
            e.pe = g;
            e.q = qr[63:32];
            e.r = qr[31:0];
            e.due = act + LAT;
            eq.push_back(e);
            m_rr = (g + 1) % NR;
         end
         act++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply('0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      eq.delete();
      m_rr = 0;
      act = 0;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      apply('0, 1'b1);
      #1;
      total++;
      if (outstanding !== 3'd0 || err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state outst=%0d err=%b want 0/0", outstanding, err);
      end
      total++;
      if (req_ready !== '0 || rsp_valid !== '0) begin
         bad++;
         $display("FAIL reset_hs rdy=%b rsp=%b want 0/0", req_ready, rsp_valid);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      ta[2] = 32'd100;
      tb_[2] = 32'd7;
      apply(4'b0100, 1'b1);
      #2;
      total++;
      if (req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL single_grant got=%b want=0100", req_ready);
      end
      drive_cycle(4'b0100, 1'b1);
      repeat (LAT - 1) drive_cycle('0, 1'b1);
      total++;
      if (rsp_valid !== 4'b0100 || rsp_q !== 32'd14 || rsp_r !== 32'd2) begin
         bad++;
         $display("FAIL single_rsp got=%b %0d/%0d want=0100 14/2",
                  rsp_valid, rsp_q, rsp_r);
      end
      drive_cycle('0, 1'b1);
   endtask

   task automatic test_all_valid();
      do_reset();
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < NR; i++) begin
            ta[i] = $urandom;
            tb_[i] = $urandom_range(1, 1000);
         end
         apply(4'hF, 1'b1);
         #1;
         total++;
         if (req_ready !== NR'(1 << (c % NR))) begin
            bad++;
            $display("FAIL rr_order c=%0d got=%b want=%b",
                     c, req_ready, NR'(1 << (c % NR)));
         end
         if (c >= LAT) begin
            total++;
            if (rsp_valid !== NR'(1 << ((c - LAT) % NR))) begin
               bad++;
               $display("FAIL rsp_order c=%0d got=%b", c, rsp_valid);
            end
         end
         drive_cycle(4'hF, 1'b1);
      end
      repeat (LAT + 1) drive_cycle('0, 1'b1);
   endtask

   task automatic test_stall();
      logic [63:0] qr;
      do_reset();
      ta[0] = 32'd1000;
      tb_[0] = 32'd33;
      qr = ref_div(ta[0], tb_[0]);
      drive_cycle(4'b0001, 1'b1);
      repeat (LAT - 1) drive_cycle('0, 1'b1);
      for (int s = 0; s < 3; s++) begin
         apply(4'hF, 1'b0);
         #1;
         total++;
         if (req_ready !== '0 || rsp_valid !== 4'b0001 ||
             rsp_q !== qr[63:32] || rsp_r !== qr[31:0]) begin
            bad++;
            $display("FAIL stall_hold s=%0d rdy=%b rsp=%b q=%0d r=%0d",
                     s, req_ready, rsp_valid, rsp_q, rsp_r);
         end
         drive_cycle(4'hF, 1'b0);
      end
      drive_cycle('0, 1'b1);
      ta[1] = 32'd77;
      tb_[1] = 32'd5;
      drive_cycle(4'b0010, 1'b1);
      drive_cycle('0, 1'b1);
      repeat (3) drive_cycle(4'b0100, 1'b0);
      repeat (LAT + 1) drive_cycle('0, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NR; i++) begin
            ta[i] = $urandom;
            tb_[i] = $urandom;
         end
         if (c == LAT) begin
            apply(4'hF, 1'b1);
            #1;
            total++;
            if (outstanding !== 3'(LAT) || rsp_valid === '0 ||
                req_ready === '0) begin
               bad++;
               $display("FAIL full_pop outst=%0d rsp=%b rdy=%b",
                        outstanding, rsp_valid, req_ready);
            end
         end
         drive_cycle(4'hF, 1'b1);
      end
      for (int s = 0; s < 3; s++) begin
         apply(4'hF, 1'b0);
         #1;
         total++;
         if (req_ready !== '0 || outstanding !== 3'(LAT)) begin
            bad++;
            $display("FAIL full_block rdy=%b outst=%0d", req_ready, outstanding);
         end
         drive_cycle(4'hF, 1'b0);
      end
      repeat (4) drive_cycle(4'hF, 1'b1);
      repeat (LAT + 1) drive_cycle('0, 1'b1);
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < NR; i++) begin
         ta[i] = $urandom;
         tb_[i] = $urandom_range(1, 50);
      end
      repeat (3) drive_cycle(4'b0111, 1'b1);
      apply('0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (outstanding !== 3'd0 || rsp_valid !== '0) begin
         bad++;
         $display("FAIL async_rst outst=%0d rsp=%b want 0", outstanding, rsp_valid);
      end
      @(posedge clk);
      #1;
      eq.delete();
      m_rr = 0;
      act = 0;
      rst_n = 1'b1;
      repeat (LAT + 3) drive_cycle('0, 1'b1);
   endtask

   task automatic test_negative();
      do_reset();
      ta[1] = -32'sd9;
      tb_[1] = 32'sd2;
      apply(4'b0010, 1'b1);
      #2;
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL neg_grant got=%b want=0010", req_ready);
      end
      drive_cycle(4'b0010, 1'b1);
      repeat (LAT - 1) drive_cycle('0, 1'b1);
      total++;
      if (rsp_valid !== 4'b0010 || rsp_q !== 32'hFFFF_FFFC ||
          rsp_r !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL neg_rsp got=%b %h/%h want=0010 fffffffc/ffffffff",
                  rsp_valid, rsp_q, rsp_r);
      end
      drive_cycle('0, 1'b1);
   endtask

   task automatic test_random();
      logic [NR-1:0] v;
      logic pr;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NR; i++) begin
            ta[i] = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
               0: tb_[i] = 32'd0;
               1: tb_[i] = 32'hFFFF_FFFF;
               default: tb_[i] = $urandom;
            endcase
         end
         v = NR'($urandom);
         pr = ($urandom_range(0, 3) != 0);
         drive_cycle(v, pr);
      end
      repeat (LAT + 2) drive_cycle('0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) begin
         ta[i] = '0;
         tb_[i] = '0;
      end
      apply('0, 1'b1);
      m_rr = 0;
      act = 0;
      #12;
      test_reset();
      test_single();
      test_all_valid();
      test_stall();
      test_back_to_back();
      test_async_reset();
      test_negative();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
